// File: rtl/alu_control_mc.sv
// alu_control_mc: ALU control decoder with a multi-cycle shift-add multiplier
// that writes the HI/LO product registers and stalls the pipeline while it runs.
module alu_control_mc #(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         ALUOp,
    input  logic [FUNCT_W-1:0] Funct,
    input  logic [WIDTH-1:0]   SrcA,
    input  logic [WIDTH-1:0]   SrcB,
    output logic [2:0]         ALUControl,
    output logic               illegal,
    output logic               busy,
    output logic               done,
    output logic               stall,
    output logic [WIDTH-1:0]   HI,
    output logic [WIDTH-1:0]   LO,
    output logic [WIDTH-1:0]   HiLoData,
    output logic               hilo_sel
);
    localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'(6'b100000);
    localparam logic [FUNCT_W-1:0] F_SUB   = FUNCT_W'(6'b100010);
    localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(6'b100100);
    localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'(6'b100101);
    localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'(6'b101010);
    localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'(6'b011000);
    localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'b011001);
    localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(6'b010000);
    localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(6'b010010);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t               r_state, w_next;
    logic [2*WIDTH-1:0]   r_acc, r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_neg;
    logic [CW-1:0]        r_cnt;
    logic                 w_rtype, w_is_mul, w_signed, w_launch;
    logic [WIDTH-1:0]     w_mag_a, w_mag_b;
    logic [2*WIDTH-1:0]   w_result;

    always_comb begin
        ALUControl = 3'b000;
        illegal    = 1'b0;
        case (ALUOp)
            2'b00: ALUControl = 3'b010;
            2'b01: ALUControl = 3'b110;
            2'b10:
                case (Funct)
                    F_ADD:           ALUControl = 3'b010;
                    F_SUB:           ALUControl = 3'b110;
                    F_AND:           ALUControl = 3'b000;
                    F_OR:            ALUControl = 3'b001;
                    F_SLT:           ALUControl = 3'b111;
                    F_MULT, F_MULTU: ALUControl = 3'b011;
                    F_MFHI, F_MFLO:  ALUControl = 3'b000;
                    default:         illegal    = 1'b1;
                endcase
            default: ALUControl = 3'b000;
        endcase
    end

    assign w_rtype  = (ALUOp == 2'b10);
    assign w_is_mul = w_rtype && (Funct == F_MULT || Funct == F_MULTU);
    assign w_signed = (Funct == F_MULT);
    assign hilo_sel = w_rtype && (Funct == F_MFHI || Funct == F_MFLO);
    assign HiLoData = hilo_sel ? ((Funct == F_MFHI) ? HI : LO) : '0;
    assign w_launch = start && w_is_mul && (r_state == IDLE);
    // Magnitudes fit unsigned WIDTH bits, including the most-negative value.
    assign w_mag_a  = (w_signed && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    assign w_mag_b  = (w_signed && SrcB[WIDTH-1]) ? -SrcB : SrcB;
    assign w_result = r_neg ? -r_acc : r_acc;
    assign stall    = busy || (w_launch) || (start && hilo_sel && busy);

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: w_next = w_launch ? MUL : IDLE;
            MUL: begin
                busy   = 1'b1;
                w_next = (r_cnt == CW'(WIDTH - 1)) ? DONE : MUL;
            end
            DONE: begin
                busy   = 1'b1;
                done   = !reset;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE:
                    if (w_launch) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_neg    <= w_signed && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                MUL: begin
                    r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                end
                DONE: {HI, LO} <= w_result;
                default: ;
            endcase
        end
    end
endmodule
